// File: rtl/fifo_burst_reader_if.sv
// rtl/fifo_burst_reader_if.sv - FIFO read port and output stream bundle for fifo_burst_reader
//
// Signals (direction as seen by the master, i.e. the burst reader):
//   fifo_empty  in   FIFO empty flag
//   fifo_rd_cs  out  FIFO read chip select
//   fifo_rd_en  out  FIFO read strobe, one word per high cycle
//   fifo_data   in   FIFO registered read data, valid the cycle after fifo_rd_en
//   m_valid     out  stream data valid
//   m_ready     in   stream consumer ready
//   m_data      out  stream data
//   m_last      out  final word of the burst
interface fifo_burst_reader_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  fifo_empty;
  logic                  fifo_rd_cs;
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_last;

  modport master (
    input  fifo_empty,
    input  fifo_data,
    input  m_ready,
    output fifo_rd_cs,
    output fifo_rd_en,
    output m_valid,
    output m_data,
    output m_last
  );

  modport slave (
    output fifo_empty,
    output fifo_data,
    output m_ready,
    input  fifo_rd_cs,
    input  fifo_rd_en,
    input  m_valid,
    input  m_data,
    input  m_last
  );
endinterface

// File: rtl/fifo_burst_reader.sv
// rtl/fifo_burst_reader.sv - read-side burst master draining a single-clock FIFO into a valid/ready stream
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   start      in   burst request pulse, sampled only in IDLE
//   burst_len  in   words to deliver, sampled with start
//   busy       out  high while a burst is active
//   done       out  one-cycle pulse after the last word is accepted
//   words_out  out  words accepted in the current or most recent burst
//   bus        master side of fifo_burst_reader_if (FIFO read port + output stream)
module fifo_burst_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] burst_len,
  output logic                 busy,
  output logic                 done,
  output logic [LEN_WIDTH-1:0] words_out,
  fifo_burst_reader_if.master  bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  logic [1:0]            state_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  issued_cnt;
  logic                  inflight_q;

  // Two-entry output buffer: enough to absorb the word already in flight
  // when the consumer stalls, so full throughput needs no extra bubble.
  logic [DATA_WIDTH-1:0] buf_q [2];
  logic                  wr_ptr_q;
  logic                  rd_ptr_q;
  logic [1:0]            occ_q;

  logic                  pop;
  logic                  rd_en;
  logic                  last_pop;
  logic [LEN_WIDTH-1:0]  last_idx;
  logic [2:0]            pending;

  assign last_idx = len_q - LEN_WIDTH'(1);
  assign pop      = bus.m_valid && bus.m_ready;
  assign last_pop = pop && (words_out == last_idx);

  // Words already owed to the buffer: stored plus the one arriving now.
  assign pending = 3'(occ_q) + 3'(inflight_q);

  // occ + inflight - pop <= 1, rearranged so the subtraction cannot underflow.
  // A strobe is only issued when the FIFO is non-empty because the FIFO
  // advances its read pointer on every strobe.
  assign rd_en = (state_q == ST_RUN)
              && !bus.fifo_empty
              && (issued_cnt != len_q)
              && (pending <= (3'(pop) + 3'd1));

  assign busy           = (state_q == ST_RUN);
  assign done           = (state_q == ST_FIN);
  assign bus.fifo_rd_cs = busy;
  assign bus.fifo_rd_en = rd_en;
  assign bus.m_valid    = (occ_q != 2'd0);
  assign bus.m_data     = buf_q[rd_ptr_q];
  assign bus.m_last     = bus.m_valid && (words_out == last_idx);

  // Burst control and counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      issued_cnt <= '0;
      words_out  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            len_q      <= burst_len;
            issued_cnt <= '0;
            words_out  <= '0;
            state_q    <= (burst_len == '0) ? ST_FIN : ST_RUN;
          end
        end
        ST_RUN: begin
          if (rd_en) begin
            issued_cnt <= issued_cnt + LEN_WIDTH'(1);
          end
          if (pop) begin
            words_out <= words_out + LEN_WIDTH'(1);
          end
          if (last_pop) begin
            state_q <= ST_FIN;
          end
        end
        ST_FIN: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Read-data capture and output buffer. inflight_q marks the cycle in
  // which the FIFO presents the word strobed one cycle earlier; clearing it
  // on reset drops any word still in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_q <= 1'b0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      occ_q      <= 2'd0;
      buf_q[0]   <= '0;
      buf_q[1]   <= '0;
    end else begin
      inflight_q <= rd_en;
      if (inflight_q) begin
        buf_q[wr_ptr_q] <= bus.fifo_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      occ_q <= occ_q + 2'(inflight_q) - 2'(pop);
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb/tb_fifo_burst_reader.sv - self-checking testbench for fifo_burst_reader
module tb_fifo_burst_reader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [8:0] burst_len = '0;
  logic       busy;
  logic       done;
  logic [8:0] words_out;

  int checks = 0;
  int errors = 0;

  fifo_burst_reader_if #(.DATA_WIDTH(8)) bus ();

  fifo_burst_reader #(.DATA_WIDTH(8), .LEN_WIDTH(9)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .burst_len (burst_len),
    .busy      (busy),
    .done      (done),
    .words_out (words_out),
    .bus       (bus.master)
  );

  always #5 clk = ~clk;

  // FIFO model: registered read data, read pointer advances on every strobe.
  logic [7:0] mem [256];
  logic [8:0] wptr = '0;
  logic [8:0] rptr = '0;
  logic [7:0] fifo_q = '0;
  logic       m_ready_drv = 1'b1;

  assign bus.fifo_empty = (wptr == rptr);
  assign bus.fifo_data  = fifo_q;
  assign bus.m_ready    = m_ready_drv;

  always @(posedge clk) begin
    if (bus.fifo_rd_en) begin
      fifo_q <= mem[rptr[7:0]];
      rptr   <= rptr + 9'd1;
    end
  end

  // Running monitors of the hard invariants and stall stability.
  int         inv_viol = 0;
  int         stall_viol = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = '0;

  always @(negedge clk) begin
    if (bus.fifo_rd_en && (bus.fifo_empty || !busy)) inv_viol <= inv_viol + 1;
    if (bus.fifo_rd_cs !== busy) inv_viol <= inv_viol + 1;
    if (prev_stall && (!bus.m_valid || (bus.m_data !== prev_data))) stall_viol <= stall_viol + 1;
    prev_stall <= bus.m_valid && !bus.m_ready && !rst;
    prev_data  <= bus.m_data;
  end

  logic [7:0] rx_q [$];

  task automatic fifo_push(input logic [7:0] d);
    mem[wptr[7:0]] = d;
    wptr = wptr + 9'd1;
  endtask

  // Runs one burst. Cycle 1 is the cycle after the edge that samples start.
  // mode 0: m_ready=1; mode 1: m_ready pattern 1,0,0 repeating.
  task automatic run_burst(input int len, input int mode, input int start_at,
                           input int push_at, input int push_n, input logic [7:0] push_base,
                           output int lat_rd, output int lat_vld, output int done_c,
                           output int last_pop_c, output int last_cnt, output logic [7:0] last_data,
                           output int max_out, output int n_strobe);
    int issued;
    int popped;
    issued = 0; popped = 0;
    lat_rd = -1; lat_vld = -1; done_c = -1; last_pop_c = -1;
    last_cnt = 0; last_data = '0; max_out = 0; n_strobe = 0;
    rx_q.delete();
    @(posedge clk); #1;
    start = 1'b1;
    burst_len = 9'(len);
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 2000; c++) begin
      m_ready_drv = (mode == 0) ? 1'b1 : (((c - 1) % 3) == 0);
      if (c == start_at) begin
        start = 1'b1;
        burst_len = 9'd7;
      end else begin
        start = 1'b0;
      end
      if (c == push_at) begin
        for (int k = 0; k < push_n; k++) fifo_push(push_base + 8'(k));
      end
      @(negedge clk);
      if (bus.fifo_rd_en) begin
        n_strobe++;
        issued++;
        if (lat_rd < 0) lat_rd = c;
      end
      if (bus.m_valid && lat_vld < 0) lat_vld = c;
      if (bus.m_valid && bus.m_ready) begin
        rx_q.push_back(bus.m_data);
        popped++;
        last_pop_c = c;
        if (bus.m_last) begin
          last_cnt++;
          last_data = bus.m_data;
        end
      end
      if (issued - popped > max_out) max_out = issued - popped;
      if (done) begin
        done_c = c;
        break;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    m_ready_drv = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, bus.fifo_rd_cs, bus.fifo_rd_en, bus.m_valid, bus.m_last} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 000000",
               {busy, done, bus.fifo_rd_cs, bus.fifo_rd_en, bus.m_valid, bus.m_last});
    end
    checks++;
    if (words_out !== 9'd0) begin errors++; $display("FAIL reset_words_out: got %0d expected 0", words_out); end
    checks++;
    if (bus.m_data !== 8'h00) begin errors++; $display("FAIL reset_m_data: got %h expected 00", bus.m_data); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_basic;
    int lr, lv, dc, lp, lc, mo, ns, bad;
    logic [7:0] ld;
    for (int i = 0; i < 5; i++) fifo_push(8'h10 + 8'(i));
    run_burst(5, 0, 0, 0, 0, 8'h00, lr, lv, dc, lp, lc, ld, mo, ns);
    checks++; if (lr !== 1) begin errors++; $display("FAIL basic_rd_latency: got %0d expected 1", lr); end
    checks++; if (lv !== 3) begin errors++; $display("FAIL basic_valid_latency: got %0d expected 3", lv); end
    checks++; if (rx_q.size() !== 5) begin errors++; $display("FAIL basic_count: got %0d expected 5", rx_q.size()); end
    bad = 0;
    foreach (rx_q[i]) if (rx_q[i] !== 8'h10 + 8'(i)) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL basic_data: got %0d wrong words expected 0", bad); end
    checks++; if (lp !== 7) begin errors++; $display("FAIL basic_last_pop_cycle: got %0d expected 7", lp); end
    checks++; if (lc !== 1 || ld !== 8'h14) begin errors++; $display("FAIL basic_m_last: got count %0d data %h expected 1 14", lc, ld); end
    checks++; if (dc !== 8) begin errors++; $display("FAIL basic_done_cycle: got %0d expected 8", dc); end
    checks++; if (ns !== 5) begin errors++; $display("FAIL basic_strobes: got %0d expected 5", ns); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got done %b busy %b expected 0 0", done, busy); end
    checks++; if (words_out !== 9'd5) begin errors++; $display("FAIL basic_words_out: got %0d expected 5", words_out); end
  endtask

  task automatic test_backpressure;
    int lr, lv, dc, lp, lc, mo, ns, bad, sv0;
    logic [7:0] ld;
    sv0 = stall_viol;
    for (int i = 0; i < 8; i++) fifo_push(8'h20 + 8'(i));
    run_burst(8, 1, 0, 0, 0, 8'h00, lr, lv, dc, lp, lc, ld, mo, ns);
    checks++; if (dc < 0) begin errors++; $display("FAIL bp_done: got timeout expected done"); end
    checks++; if (rx_q.size() !== 8) begin errors++; $display("FAIL bp_count: got %0d expected 8", rx_q.size()); end
    bad = 0;
    foreach (rx_q[i]) if (rx_q[i] !== 8'h20 + 8'(i)) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL bp_data: got %0d wrong words expected 0", bad); end
    checks++; if (stall_viol !== sv0) begin errors++; $display("FAIL bp_stall_stable: got %0d violations expected 0", stall_viol - sv0); end
    checks++; if (mo > 2) begin errors++; $display("FAIL bp_outstanding: got %0d expected <=2", mo); end
    checks++; if (ns !== 8) begin errors++; $display("FAIL bp_strobes: got %0d expected 8", ns); end
    checks++; if (lc !== 1 || ld !== 8'h27) begin errors++; $display("FAIL bp_m_last: got count %0d data %h expected 1 27", lc, ld); end
    @(posedge clk); #1;
    checks++; if (words_out !== 9'd8) begin errors++; $display("FAIL bp_words_out: got %0d expected 8", words_out); end
  endtask

  task automatic test_starvation;
    int lr, lv, dc, lp, lc, mo, ns, bad;
    logic [7:0] ld;
    fifo_push(8'h30);
    fifo_push(8'h31);
    run_burst(4, 0, 0, 10, 2, 8'h32, lr, lv, dc, lp, lc, ld, mo, ns);
    checks++; if (rx_q.size() !== 4) begin errors++; $display("FAIL starve_count: got %0d expected 4", rx_q.size()); end
    bad = 0;
    foreach (rx_q[i]) if (rx_q[i] !== 8'h30 + 8'(i)) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL starve_data: got %0d wrong words expected 0", bad); end
    checks++; if (ns !== 4) begin errors++; $display("FAIL starve_strobes: got %0d expected 4", ns); end
    checks++; if (lp !== 13) begin errors++; $display("FAIL starve_last_pop: got %0d expected 13", lp); end
    checks++; if (dc !== 14) begin errors++; $display("FAIL starve_done_cycle: got %0d expected 14", dc); end
  endtask

  task automatic test_zero_and_ignored_start;
    int lr, lv, dc, lp, lc, mo, ns, bad;
    logic [7:0] ld;
    @(posedge clk); #1;
    start = 1'b1;
    burst_len = 9'd0;
    @(posedge clk); #1;
    burst_len = 9'd2;  // start still high during FIN: must be ignored
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || bus.m_valid !== 1'b0) begin
      errors++;
      $display("FAIL zero_done: got done %b busy %b m_valid %b expected 1 0 0", done, busy, bus.m_valid);
    end
    @(posedge clk); #1;
    start = 1'b0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (busy || done || bus.fifo_rd_en) bad++;
      @(posedge clk); #1;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL fin_start_ignored: got %0d active cycles expected 0", bad); end
    checks++; if (words_out !== 9'd0) begin errors++; $display("FAIL zero_words_out: got %0d expected 0", words_out); end

    for (int i = 0; i < 3; i++) fifo_push(8'h50 + 8'(i));
    run_burst(3, 0, 2, 0, 0, 8'h00, lr, lv, dc, lp, lc, ld, mo, ns);
    checks++; if (dc !== 6) begin errors++; $display("FAIL ign_done_cycle: got %0d expected 6", dc); end
    checks++; if (rx_q.size() !== 3 || ns !== 3) begin errors++; $display("FAIL ign_count: got %0d words %0d strobes expected 3 3", rx_q.size(), ns); end
    @(posedge clk); #1;
    checks++; if (words_out !== 9'd3) begin errors++; $display("FAIL ign_words_out: got %0d expected 3", words_out); end
  endtask

  task automatic test_reset_mid_burst;
    int lr, lv, dc, lp, lc, mo, ns;
    logic [7:0] ld;
    for (int i = 0; i < 4; i++) fifo_push(8'h40 + 8'(i));
    @(posedge clk); #1;
    start = 1'b1;
    burst_len = 9'd4;
    m_ready_drv = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);  // cycle 3
    checks++;
    if (bus.fifo_rd_en !== 1'b1 || bus.m_valid !== 1'b1 || bus.m_data !== 8'h40) begin
      errors++;
      $display("FAIL rmb_pre: got rd_en %b m_valid %b m_data %h expected 1 1 40", bus.fifo_rd_en, bus.m_valid, bus.m_data);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, done, bus.fifo_rd_cs, bus.fifo_rd_en, bus.m_valid, bus.m_last} !== 6'b0 || words_out !== 9'd0 || bus.m_data !== 8'h00) begin
      errors++;
      $display("FAIL rmb_reset: got flags %b words_out %0d m_data %h expected 000000 0 00",
               {busy, done, bus.fifo_rd_cs, bus.fifo_rd_en, bus.m_valid, bus.m_last}, words_out, bus.m_data);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    run_burst(1, 0, 0, 0, 0, 8'h00, lr, lv, dc, lp, lc, ld, mo, ns);
    checks++; if (lv !== 3) begin errors++; $display("FAIL rmb_latency: got %0d expected 3", lv); end
    checks++;
    if (rx_q.size() !== 1 || rx_q[0] !== 8'h43) begin
      errors++;
      $display("FAIL rmb_data: got %0d words first %h expected 1 43", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'h00);
    end
    checks++; if (dc !== 4) begin errors++; $display("FAIL rmb_done_cycle: got %0d expected 4", dc); end
  endtask

  task automatic test_full_depth;
    int lr, lv, dc, lp, lc, mo, ns, bad;
    logic [7:0] ld;
    for (int i = 0; i < 255; i++) fifo_push(8'(i));
    run_burst(255, 0, 0, 0, 0, 8'h00, lr, lv, dc, lp, lc, ld, mo, ns);
    checks++; if (rx_q.size() !== 255) begin errors++; $display("FAIL full_count: got %0d expected 255", rx_q.size()); end
    bad = 0;
    foreach (rx_q[i]) if (rx_q[i] !== 8'(i)) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL full_data: got %0d wrong words expected 0", bad); end
    checks++; if (ns !== 255) begin errors++; $display("FAIL full_strobes: got %0d expected 255", ns); end
    checks++; if (dc !== 258) begin errors++; $display("FAIL full_done_cycle: got %0d expected 258", dc); end
    checks++; if (lc !== 1 || ld !== 8'hFE) begin errors++; $display("FAIL full_m_last: got count %0d data %h expected 1 fe", lc, ld); end
    @(posedge clk); #1;
    checks++; if (words_out !== 9'd255) begin errors++; $display("FAIL full_words_out: got %0d expected 255", words_out); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_starvation();
    test_zero_and_ignored_start();
    test_reset_mid_burst();
    test_full_depth();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (inv_viol !== 0) begin errors++; $display("FAIL strobe_invariant: got %0d violations expected 0", inv_viol); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_burst_reader.md
# fifo_burst_reader

Read-side master for the single-clock FIFO. It drains a requested number of words from the FIFO read port and presents them as a valid/ready stream at full throughput. The FIFO returns registered read data one cycle after a read strobe, so the block keeps a 2-entry output buffer with in-flight credit tracking. It never strobes an empty FIFO, because the FIFO read pointer advances on every strobe regardless of occupancy.

## Interface
- DATA_WIDTH, 8: word width; matches the FIFO data width.
- LEN_WIDTH, 9: width of burst_len and words_out; covers a full 256-deep FIFO.
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  burst request pulse; sampled only in IDLE.
- burst_len  in  LEN_WIDTH  words to deliver; sampled with start.
- busy  out  1  high while a burst is active.
- done  out  1  one-cycle pulse after the last word is accepted.
- words_out  out  LEN_WIDTH  words accepted downstream in the current or most recent burst.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_cs  out  1  FIFO read chip select; equals busy.
- fifo_rd_en  out  1  FIFO read strobe; one word per high cycle.
- fifo_data  in  DATA_WIDTH  FIFO registered read data; valid the cycle after fifo_rd_en.
- m_valid  out  1  stream data valid.
- m_ready  in  1  stream consumer ready.
- m_data  out  DATA_WIDTH  stream data.
- m_last  out  1  high with the final word of the burst.

## Operation
- States:
  - IDLE: busy=0, fifo_rd_en=0. start → RUN, or → FIN if burst_len==0. Latch burst_len into len_q; clear issued_cnt and words_out.
  - RUN: issues reads and delivers words. → FIN on the edge where the last word is accepted (pop && words_out==len_q-1).
  - FIN: done=1 for exactly one cycle, busy=0. → IDLE.
- Outputs in FIN: m_valid=0, and start is ignored.
- Counter: issued_cnt counts strobes.
- Credit rule:
  - inflight = 1 if fifo_rd_en was high in the previous cycle.
  - occ = buffer occupancy, 0..2.
  - pop = m_valid && m_ready.
- Strobe rule: fifo_rd_en = (state==RUN) && !fifo_empty && (issued_cnt != len_q) && (occ + inflight - pop <= 1). It is combinational from registered state, fifo_empty and m_ready.
- Capture: when inflight is set, write fifo_data into the buffer tail. Buffer order is strict FIFO.
- Stream output: m_valid = occ != 0; m_data = buffer head. m_data and m_valid hold stable while m_valid && !m_ready.
- m_last = m_valid && (words_out == len_q-1).
- words_out increments on each pop and holds its value through IDLE until the next start.
- start while busy or in FIN is ignored; burst_len is not re-sampled.
- Arithmetic: counters are LEN_WIDTH unsigned with no wrap, since issued_cnt ≤ len_q. Maximum burst is 2^LEN_WIDTH-1.
- fifo_empty deasserting mid-burst: reads resume the same cycle. A starved burst stays in RUN indefinitely; there is no timeout.

## Timing
- Reset values: busy=0, done=0, words_out=0, fifo_rd_cs=0, fifo_rd_en=0, m_valid=0, m_data=0, m_last=0. The buffer is emptied and the state is IDLE.
- Reset mid-burst: everything returns to reset values immediately. Any in-flight FIFO word is discarded and not captured.
- Latency, with FIFO non-empty and m_ready=1:
  - start sampled at edge 0.
  - fifo_rd_en high in cycle 1.
  - fifo_data valid and captured in cycle 2.
  - m_valid first high in cycle 3.
- Throughput: one word per cycle sustained while m_ready=1 and the FIFO is non-empty.
- Backpressure: with m_ready=0, at most 2 words are buffered and strobes stop once occ+inflight==2.
- done is high the cycle after the final pop edge. busy falls on that same edge; the next start is accepted in the IDLE cycle after done.
- Hard invariant: fifo_rd_en is never high while fifo_empty=1 or while busy=0.

## Test plan
- Basic burst: FIFO preloaded 0x10..0x14, start with burst_len=5, m_ready=1 → m_data 0x10..0x14 on consecutive cycles 3..7; m_last on 0x14; done pulse in cycle 8; words_out=5; exactly 5 fifo_rd_en cycles.
- Backpressure: FIFO holds 8 words, burst_len=8, m_ready toggles 1,0,0,1,… → data in order with no loss or duplicates; m_data stable while stalled; occ never exceeds 2; exactly 8 strobes.
- Starvation: FIFO holds 2 words, burst_len=4; write 2 more words 10 cycles later → fifo_rd_en stays 0 while fifo_empty=1; burst completes with 4 words and done after the 4th pop.
- Zero length and ignored start: burst_len=0 → no strobes, done one cycle after start. start pulsed mid-burst → no effect on len_q or words_out.
- Reset mid-burst: assert rst in the cycle after a strobe with occ=1 → all outputs return to reset values that cycle. A new burst_len=1 burst then returns the next FIFO word with the standard 3-cycle latency.
- Full-depth burst: 255 words preloaded, burst_len=255 → 255 words in order; words_out=255; no strobe after the 255th.
